// File: rtl/dma_regs.sv
// CPU-side register front end for the DMA engine: holds src/dst/len/ctrl, launches
// transfers, tracks engine busy, stalls the CPU and latches a completion interrupt.
module dma_regs #(
  parameter int unsigned ARM_TIMEOUT = 15,
  parameter bit          STALL_CPU   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_rdy,
  output logic [7:0]  dma_ctrl,
  output logic [15:0] dma_src,
  output logic [15:0] dma_dst,
  output logic [7:0]  dma_len,
  input  logic        dma_busy,
  output logic        irq
);

  localparam int unsigned CNT_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARM_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [7:0]       src_lo_q, src_lo_d, src_hi_q, src_hi_d;
  logic [7:0]       dst_lo_q, dst_lo_d, dst_hi_q, dst_hi_d;
  logic [7:0]       len_q, len_d;
  logic [6:0]       ctrl_q, ctrl_d;
  logic             start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             irq_pending_q, irq_pending_d;
  logic [7:0]       dout_q, dout_d;
  logic             rdy_q, rdy_d;

  logic wr_en_c;
  logic rd_en_c;
  logic reg_wr_c;

  assign wr_en_c  = cpu_cs & cpu_we;
  assign rd_en_c  = cpu_cs & ~cpu_we;
  // Configuration registers are frozen while a transfer is in flight.
  assign reg_wr_c = wr_en_c & (state_q == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      src_lo_q      <= 8'h00;
      src_hi_q      <= 8'h00;
      dst_lo_q      <= 8'h00;
      dst_hi_q      <= 8'h00;
      len_q         <= 8'h00;
      ctrl_q        <= 7'h00;
      start_q       <= 1'b0;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
      irq_pending_q <= 1'b0;
      dout_q        <= 8'h00;
      rdy_q         <= 1'b1;
    end else begin
      state_q       <= state_d;
      src_lo_q      <= src_lo_d;
      src_hi_q      <= src_hi_d;
      dst_lo_q      <= dst_lo_d;
      dst_hi_q      <= dst_hi_d;
      len_q         <= len_d;
      ctrl_q        <= ctrl_d;
      start_q       <= start_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
      irq_pending_q <= irq_pending_d;
      dout_q        <= dout_d;
      rdy_q         <= rdy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    src_lo_d      = src_lo_q;
    src_hi_d      = src_hi_q;
    dst_lo_d      = dst_lo_q;
    dst_hi_d      = dst_hi_q;
    len_d         = len_q;
    ctrl_d        = ctrl_q;
    start_d       = start_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    irq_pending_d = irq_pending_q;
    dout_d        = dout_q;

    if (rd_en_c) begin
      case (cpu_addr)
        3'd0:    dout_d = src_lo_q;
        3'd1:    dout_d = src_hi_q;
        3'd2:    dout_d = dst_lo_q;
        3'd3:    dout_d = dst_hi_q;
        3'd4:    dout_d = len_q;
        3'd5:    dout_d = {(state_q != S_IDLE), ctrl_q};
        3'd6:    dout_d = {irq_pending_q, dma_busy, timeout_q, 3'b000, state_q};
        default: dout_d = 8'h00;
      endcase
    end

    if (reg_wr_c) begin
      case (cpu_addr)
        3'd0:    src_lo_d = cpu_din;
        3'd1:    src_hi_d = cpu_din;
        3'd2:    dst_lo_d = cpu_din;
        3'd3:    dst_hi_d = cpu_din;
        3'd4:    len_d    = cpu_din;
        default: ;
      endcase
    end

    // Ack first so a coincident DONE set below takes priority.
    if (wr_en_c && (cpu_addr == 3'd6) && cpu_din[0]) begin
      irq_pending_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (reg_wr_c && (cpu_addr == 3'd5)) begin
          ctrl_d = cpu_din[6:0];
          if (cpu_din[7]) begin
            start_d   = 1'b1;
            cnt_d     = '0;
            timeout_d = 1'b0;
            state_d   = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (dma_busy) begin
          start_d = 1'b0;
          state_d = S_RUN;
        end else if (cnt_q == CNT_LAST) begin
          start_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!dma_busy) begin
          state_d = S_DONE;
        end
      end
      default: begin
        start_d = 1'b0;
        if (ctrl_q[0]) begin
          irq_pending_d = 1'b1;
        end
        state_d = S_IDLE;
      end
    endcase

    rdy_d = !(STALL_CPU && ((state_d == S_ARM) || (state_d == S_RUN)));
  end

  assign cpu_dout = dout_q;
  assign cpu_rdy  = rdy_q;
  assign dma_ctrl = {start_q, ctrl_q};
  assign dma_src  = {src_hi_q, src_lo_q};
  assign dma_dst  = {dst_hi_q, dst_lo_q};
  assign dma_len  = len_q;
  assign irq      = irq_pending_q;

endmodule

// File: tb/tb_dma_regs.sv
// Directed bench for dma_regs: register table, launch/run, ack race, timeout,
// ignored writes and asynchronous reset mid-transfer.
module tb_dma_regs;

  logic        clk;
  logic        reset_n;
  logic        cpu_cs;
  logic        cpu_we;
  logic [2:0]  cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_rdy;
  logic [7:0]  dma_ctrl;
  logic [15:0] dma_src;
  logic [15:0] dma_dst;
  logic [7:0]  dma_len;
  logic        dma_busy;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;

  dma_regs #(.ARM_TIMEOUT(15), .STALL_CPU(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_cs   (cpu_cs),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_rdy  (cpu_rdy),
    .dma_ctrl (dma_ctrl),
    .dma_src  (dma_src),
    .dma_dst  (dma_dst),
    .dma_len  (dma_len),
    .dma_busy (dma_busy),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
    logic [15:0] exp_src;
    logic [15:0] exp_dst;
    logic [7:0]  exp_len;
    logic [7:0]  exp_ctrl;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; one bus cycle, returns at the following negedge.
  task automatic bus(input logic we, input logic [2:0] a, input logic [7:0] d);
    cpu_cs   = 1'b1;
    cpu_we   = we;
    cpu_addr = a;
    cpu_din  = d;
    @(negedge clk);
    cpu_cs   = 1'b0;
    cpu_we   = 1'b0;
  endtask

  initial begin
    int n;
    logic ok;

    vecs[0]  = '{1'b1, 3'd0, 8'h34, 8'h00, 16'h0034, 16'h0000, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 3'd1, 8'h12, 8'h00, 16'h1234, 16'h0000, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 3'd2, 8'h00, 8'h00, 16'h1234, 16'h0000, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 3'd3, 8'h40, 8'h00, 16'h1234, 16'h4000, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 3'd4, 8'h02, 8'h00, 16'h1234, 16'h4000, 8'h02, 8'h00};
    vecs[5]  = '{1'b0, 3'd1, 8'h00, 8'h12, 16'h1234, 16'h4000, 8'h02, 8'h00};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 8'h34, 16'h1234, 16'h4000, 8'h02, 8'h00};
    vecs[7]  = '{1'b0, 3'd7, 8'h00, 8'h00, 16'h1234, 16'h4000, 8'h02, 8'h00};
    vecs[8]  = '{1'b0, 3'd3, 8'h00, 8'h40, 16'h1234, 16'h4000, 8'h02, 8'h00};
    vecs[9]  = '{1'b0, 3'd4, 8'h00, 8'h02, 16'h1234, 16'h4000, 8'h02, 8'h00};
    vecs[10] = '{1'b1, 3'd5, 8'h01, 8'h02, 16'h1234, 16'h4000, 8'h02, 8'h01};
    vecs[11] = '{1'b0, 3'd5, 8'h00, 8'h01, 16'h1234, 16'h4000, 8'h02, 8'h01};
    vecs[12] = '{1'b0, 3'd6, 8'h00, 8'h00, 16'h1234, 16'h4000, 8'h02, 8'h01};

    reset_n  = 1'b0;
    cpu_cs   = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = 3'd0;
    cpu_din  = 8'h00;
    dma_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", 16'(cpu_dout), 16'h00);
    chk("rst_rdy",  16'(cpu_rdy),  16'h1);
    chk("rst_ctrl", 16'(dma_ctrl), 16'h00);
    chk("rst_irq",  16'(irq),      16'h0);
    chk("rst_src",  dma_src,       16'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    // Register map table
    for (int i = 0; i < 13; i++) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].din);
      if (!vecs[i].we) chk($sformatf("tbl%0d_dout", i), 16'(cpu_dout), 16'(vecs[i].exp_dout));
      chk($sformatf("tbl%0d_src", i),  dma_src, vecs[i].exp_src);
      chk($sformatf("tbl%0d_dst", i),  dma_dst, vecs[i].exp_dst);
      chk($sformatf("tbl%0d_len", i),  16'(dma_len),  16'(vecs[i].exp_len));
      chk($sformatf("tbl%0d_ctrl", i), 16'(dma_ctrl), 16'(vecs[i].exp_ctrl));
      chk($sformatf("tbl%0d_rdy", i),  16'(cpu_rdy),  16'h1);
    end

    // Launch, busy two cycles later, ignored writes while running
    bus(1'b1, 3'd5, 8'h81);
    chk("arm_ctrl", 16'(dma_ctrl), 16'h81);
    chk("arm_rdy",  16'(cpu_rdy),  16'h0);
    @(negedge clk);
    chk("arm_ctrl2", 16'(dma_ctrl), 16'h81);
    dma_busy = 1'b1;
    @(negedge clk);
    chk("run_ctrl", 16'(dma_ctrl), 16'h01);
    chk("run_rdy",  16'(cpu_rdy),  16'h0);
    bus(1'b1, 3'd0, 8'hFF);
    bus(1'b1, 3'd5, 8'hFF);
    chk("ign_src",  dma_src,        16'h1234);
    chk("ign_ctrl", 16'(dma_ctrl),  16'h01);
    bus(1'b0, 3'd6, 8'h00);
    chk("run_status", 16'(cpu_dout), 16'h42);
    bus(1'b0, 3'd5, 8'h00);
    chk("run_rd5", 16'(cpu_dout), 16'h81);
    ok = 1'b1;
    repeat (58) begin
      @(negedge clk);
      if (cpu_rdy !== 1'b0 || dma_ctrl !== 8'h01 || dma_src !== 16'h1234 ||
          dma_dst !== 16'h4000 || dma_len !== 8'h02) ok = 1'b0;
    end
    chk("run_stable", 16'(ok), 16'h1);
    dma_busy = 1'b0;
    @(negedge clk);
    chk("done_rdy",  16'(cpu_rdy),  16'h1);
    chk("done_ctrl", 16'(dma_ctrl), 16'h01);
    chk("done_irq0", 16'(irq),      16'h0);
    // Ack in the DONE cycle: set wins
    bus(1'b1, 3'd6, 8'h01);
    chk("race_irq", 16'(irq), 16'h1);
    bus(1'b0, 3'd6, 8'h00);
    chk("idle_status", 16'(cpu_dout), 16'h80);
    bus(1'b1, 3'd6, 8'h01);
    chk("ack_irq", 16'(irq), 16'h0);

    // Timeout with busy held low
    bus(1'b1, 3'd5, 8'h81);
    n = 0;
    while (cpu_rdy === 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 16'(n), 16'd15);
    chk("to_ctrl",   16'(dma_ctrl), 16'h01);
    @(negedge clk);
    chk("to_irq", 16'(irq), 16'h1);
    bus(1'b0, 3'd6, 8'h00);
    chk("to_status", 16'(cpu_dout), 16'hA0);

    // Busy already high on entry to ARM; timeout flag cleared by launch
    dma_busy = 1'b1;
    bus(1'b1, 3'd5, 8'h80);
    bus(1'b0, 3'd6, 8'h00);
    chk("pre_status_arm", 16'(cpu_dout), 16'hC1);
    bus(1'b0, 3'd6, 8'h00);
    chk("pre_status_run", 16'(cpu_dout), 16'hC2);
    dma_busy = 1'b0;
    @(negedge clk);
    chk("pre_done_rdy", 16'(cpu_rdy), 16'h1);
    @(negedge clk);
    chk("pre_irq_kept", 16'(irq),      16'h1);
    chk("pre_ctrl",     16'(dma_ctrl), 16'h00);

    // Asynchronous reset mid-RUN
    dma_busy = 1'b1;
    bus(1'b1, 3'd5, 8'h81);
    @(negedge clk);
    chk("mid_rdy", 16'(cpu_rdy), 16'h0);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_ctrl", 16'(dma_ctrl), 16'h00);
    chk("ar_rdy",  16'(cpu_rdy),  16'h1);
    chk("ar_irq",  16'(irq),      16'h0);
    chk("ar_src",  dma_src,       16'h0000);
    dma_busy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus(1'b0, 3'd6, 8'h00);
    chk("post_status", 16'(cpu_dout), 16'h00);
    chk("post_ctrl",   16'(dma_ctrl), 16'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
